// File: rtl/pipe_pm_ctrl.sv
// PIPE MAC-side power-management and reset sequencer: owns PhyReset, Powerdown and
// TxElecIdle, runs the PhyStatus handshakes, flags illegal requests, timeouts and wake.
module pipe_pm_ctrl #(
  parameter int unsigned RESET_CYCLES      = 16,
  parameter int unsigned PHYSTATUS_TIMEOUT = 255
) (
  input  logic       PCLK,
  input  logic       Reset_n,
  input  logic       PmReqValid,
  input  logic [1:0] PmReqState,
  output logic       PmReqReady,
  input  logic       TxElecIdleReq,
  input  logic       PhyStatus,
  input  logic       RxElecIdle,
  output logic       PhyReset,
  output logic [1:0] Powerdown,
  output logic       TxElecIdle,
  output logic       PhyReady,
  output logic       PmDone,
  output logic [1:0] PmStatus,
  output logic [1:0] CurState,
  output logic       Wake
);

  localparam int unsigned MaxCnt = (RESET_CYCLES > PHYSTATUS_TIMEOUT) ? RESET_CYCLES : PHYSTATUS_TIMEOUT;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [1:0] P0  = 2'b00;
  localparam logic [1:0] P0S = 2'b01;
  localparam logic [1:0] P1  = 2'b10;
  localparam logic [1:0] P2  = 2'b11;

  localparam logic [1:0] StatOk      = 2'b00;
  localparam logic [1:0] StatIllegal = 2'b01;
  localparam logic [1:0] StatTimeout = 2'b10;

  typedef enum logic [2:0] {
    RST_ASSERT, RST_WAIT, IDLE, PRE_IDLE, PD_WAIT, ERROR
  } state_t;

  state_t          state, stateNext;
  logic [CntW-1:0] cnt, cntNext;
  logic [1:0]      tgt, tgtNext;
  logic            rxPrev;

  logic            phyResetNext, phyReadyNext, reqReadyNext, txIdleNext;
  logic            pmDoneNext, wakeNext;
  logic [1:0]      powerdownNext, pmStatusNext, curNext;

  // Only adjacent power states may be requested: P0<->P0s, P0<->P1, P1<->P2.
  function automatic logic isLegal(input logic [1:0] from, input logic [1:0] to);
    case ({from, to})
      {P0, P0S}, {P0S, P0}, {P0, P1}, {P1, P0}, {P1, P2}, {P2, P1}: isLegal = 1'b1;
      default: isLegal = 1'b0;
    endcase
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    stateNext     = state;
    cntNext       = '0;
    tgtNext       = tgt;
    powerdownNext = Powerdown;
    curNext       = CurState;
    pmDoneNext    = 1'b0;
    pmStatusNext  = PmStatus;

    case (state)
      RST_ASSERT: begin
        if (cnt == CntW'(RESET_CYCLES - 1)) stateNext = RST_WAIT;
        else                                cntNext   = cnt + CntW'(1);
      end
      RST_WAIT: begin
        if (PhyStatus)                                stateNext = IDLE;
        else if (cnt == CntW'(PHYSTATUS_TIMEOUT - 1)) stateNext = ERROR;
        else                                          cntNext   = cnt + CntW'(1);
      end
      IDLE: begin
        if (PmReqValid && PmReqReady) begin
          if (PmReqState == CurState) begin
            pmDoneNext   = 1'b1;
            pmStatusNext = StatOk;
          end else if (!isLegal(CurState, PmReqState)) begin
            pmDoneNext   = 1'b1;
            pmStatusNext = StatIllegal;
          end else begin
            tgtNext = PmReqState;
            // Leaving P0 needs one cycle of forced electrical idle first.
            if (CurState == P0) begin
              stateNext = PRE_IDLE;
            end else begin
              stateNext     = PD_WAIT;
              powerdownNext = PmReqState;
            end
          end
        end
      end
      PRE_IDLE: begin
        stateNext     = PD_WAIT;
        powerdownNext = tgt;
      end
      PD_WAIT: begin
        if (PhyStatus) begin
          stateNext    = IDLE;
          curNext      = tgt;
          pmDoneNext   = 1'b1;
          pmStatusNext = StatOk;
        end else if (cnt == CntW'(PHYSTATUS_TIMEOUT - 1)) begin
          stateNext    = ERROR;
          pmDoneNext   = 1'b1;
          pmStatusNext = StatTimeout;
        end else begin
          cntNext = cnt + CntW'(1);
        end
      end
      ERROR:   stateNext = ERROR;
      default: stateNext = RST_ASSERT;
    endcase

    phyResetNext = (stateNext != RST_ASSERT);
    phyReadyNext = (stateNext == IDLE) || (stateNext == PRE_IDLE) || (stateNext == PD_WAIT);
    reqReadyNext = (stateNext == IDLE);
    txIdleNext   = ((stateNext == IDLE) && (curNext == P0)) ? TxElecIdleReq : 1'b1;
    wakeNext     = (state == IDLE) && (CurState != P0) && rxPrev && !RxElecIdle;
  end

  // State and registered outputs.
  always_ff @(posedge PCLK) begin
    if (!Reset_n) begin
      state      <= RST_ASSERT;
      cnt        <= '0;
      tgt        <= P1;
      rxPrev     <= 1'b0;
      PhyReset   <= 1'b0;
      Powerdown  <= P1;
      CurState   <= P1;
      TxElecIdle <= 1'b1;
      PhyReady   <= 1'b0;
      PmReqReady <= 1'b0;
      PmDone     <= 1'b0;
      PmStatus   <= StatOk;
      Wake       <= 1'b0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      tgt        <= tgtNext;
      rxPrev     <= RxElecIdle;
      PhyReset   <= phyResetNext;
      Powerdown  <= powerdownNext;
      CurState   <= curNext;
      TxElecIdle <= txIdleNext;
      PhyReady   <= phyReadyNext;
      PmReqReady <= reqReadyNext;
      PmDone     <= pmDoneNext;
      PmStatus   <= pmStatusNext;
      Wake       <= wakeNext;
    end
  end

endmodule

// File: tb/tb_pipe_pm_ctrl.sv
// Bench for pipe_pm_ctrl: random power-state traffic against a transaction-level model,
// completions checked through a scoreboard queue popped on every PmDone.
module tb_pipe_pm_ctrl;

  localparam int unsigned RstCycles = 16;
  localparam int unsigned Timeout   = 255;

  logic       PCLK = 1'b0;
  logic       Reset_n = 1'b0;
  logic       PmReqValid = 1'b0;
  logic [1:0] PmReqState = 2'b00;
  logic       PmReqReady;
  logic       TxElecIdleReq = 1'b0;
  logic       PhyStatus = 1'b0;
  logic       RxElecIdle = 1'b1;
  logic       PhyReset;
  logic [1:0] Powerdown;
  logic       TxElecIdle;
  logic       PhyReady;
  logic       PmDone;
  logic [1:0] PmStatus;
  logic [1:0] CurState;
  logic       Wake;

  pipe_pm_ctrl #(.RESET_CYCLES(RstCycles), .PHYSTATUS_TIMEOUT(Timeout)) dut (
    .PCLK(PCLK), .Reset_n(Reset_n), .PmReqValid(PmReqValid), .PmReqState(PmReqState),
    .PmReqReady(PmReqReady), .TxElecIdleReq(TxElecIdleReq), .PhyStatus(PhyStatus),
    .RxElecIdle(RxElecIdle), .PhyReset(PhyReset), .Powerdown(Powerdown),
    .TxElecIdle(TxElecIdle), .PhyReady(PhyReady), .PmDone(PmDone), .PmStatus(PmStatus),
    .CurState(CurState), .Wake(Wake)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [1:0] status;
    logic [1:0] cur;
  } exp_t;

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [1:0] mCur = 2'b10;
  logic       mTxReq = 1'b0;
  bit         legalTab[4][4];

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  function automatic int expTx();
    return (mCur == 2'b00) ? int'(mTxReq) : 1;
  endfunction

  // Completion monitor: every PmDone must match the oldest outstanding expectation.
  always @(negedge PCLK) begin
    exp_t e;
    if (PmDone) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpectedDone: got PmDone=1 status %0d, expected no completion", PmStatus);
      end else begin
        e = expQ.pop_front();
        chk("doneStatus", PmStatus, e.status);
        chk("doneCurState", CurState, e.cur);
      end
    end
  end

  task automatic checkIdle(input string tag);
    chk({tag, ".phyReset"}, PhyReset, 1);
    chk({tag, ".phyReady"}, PhyReady, 1);
    chk({tag, ".reqReady"}, PmReqReady, 1);
    chk({tag, ".powerdown"}, Powerdown, mCur);
    chk({tag, ".curState"}, CurState, mCur);
    chk({tag, ".txElecIdle"}, TxElecIdle, expTx());
    chk({tag, ".wake"}, Wake, 0);
  endtask

  task automatic checkResetVals(input string tag);
    chk({tag, ".phyReset"}, PhyReset, 0);
    chk({tag, ".powerdown"}, Powerdown, 2);
    chk({tag, ".curState"}, CurState, 2);
    chk({tag, ".txElecIdle"}, TxElecIdle, 1);
    chk({tag, ".phyReady"}, PhyReady, 0);
    chk({tag, ".reqReady"}, PmReqReady, 0);
    chk({tag, ".pmDone"}, PmDone, 0);
    chk({tag, ".pmStatus"}, PmStatus, 0);
    chk({tag, ".wake"}, Wake, 0);
  endtask

  // Release reset, measure PhyReset low time, then answer with PhyStatus after d cycles.
  task automatic powerUp(input int d);
    int low = 0;
    bit done = 0;
    Reset_n = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (PhyReset) done = 1;
      else begin
        low++;
        tick();
      end
    end
    chk("phyResetLowCycles", low, RstCycles);
    for (int i = 0; i < d; i++) begin
      chk("rstWaitNotReady", PhyReady, 0);
      tick();
    end
    PhyStatus = 1'b1;
    tick();
    PhyStatus = 1'b0;
    mCur = 2'b10;
    checkIdle("powerUp");
  endtask

  task automatic doReq(input logic [1:0] tgt, input int d, input bit abandon);
    logic [1:0] from = mCur;
    chk("reqReadyBefore", PmReqReady, 1);
    PmReqValid = 1'b1;
    PmReqState = tgt;
    if (tgt == from || !legalTab[from][tgt]) begin
      expQ.push_back({(tgt == from) ? 2'b00 : 2'b01, from});
      tick();
      PmReqValid = 1'b0;
      checkIdle("afterReject");
      tick();
      chk("rejectDoneSeen", expQ.size(), 0);
    end else begin
      if (!abandon) expQ.push_back({2'b00, tgt});
      tick();
      PmReqValid = 1'b0;
      chk("busyReqReady", PmReqReady, 0);
      chk("busyTxIdle", TxElecIdle, 1);
      chk("busyPhyReady", PhyReady, 1);
      if (from == 2'b00) begin
        chk("preIdlePowerdown", Powerdown, from);
        tick();
        chk("preIdleTxIdle", TxElecIdle, 1);
      end
      chk("newPowerdown", Powerdown, tgt);
      if (abandon) begin
        tick();
        tick();
      end else begin
        for (int i = 0; i < d; i++) begin
          chk("pdWaitReqReady", PmReqReady, 0);
          chk("pdWaitCurState", CurState, from);
          tick();
        end
        PhyStatus = 1'b1;
        tick();
        PhyStatus = 1'b0;
        mCur = tgt;
        checkIdle("complete");
        tick();
        chk("completeDoneSeen", expQ.size(), 0);
      end
    end
  endtask

  // PhyStatus never comes: completion with timeout status, then ERROR until reset.
  task automatic doTimeout(input logic [1:0] tgt);
    logic [1:0] from = mCur;
    expQ.push_back({2'b10, from});
    PmReqValid = 1'b1;
    PmReqState = tgt;
    tick();
    PmReqValid = 1'b0;
    for (int i = 0; i < int'(Timeout) - 1; i++) begin
      chk("pdWaitAlive", PhyReady, 1);
      tick();
    end
    chk("pdWaitLastCycle", PhyReady, 1);
    tick();
    chk("errPhyReady", PhyReady, 0);
    chk("errReqReady", PmReqReady, 0);
    chk("errTxIdle", TxElecIdle, 1);
    chk("errPowerdown", Powerdown, tgt);
    chk("errCurState", CurState, from);
    PmReqValid = 1'b1;
    PmReqState = from;
    for (int i = 0; i < 6; i++) begin
      PhyStatus = (i % 2 == 0);
      tick();
      chk("errHoldReqReady", PmReqReady, 0);
      chk("errHoldPhyReady", PhyReady, 0);
    end
    PmReqValid = 1'b0;
    PhyStatus = 1'b0;
    chk("timeoutDoneSeen", expQ.size(), 0);
  endtask

  task automatic setTxReq(input logic v);
    mTxReq = v;
    TxElecIdleReq = v;
    tick();
    chk("txFollowsReq", TxElecIdle, expTx());
  endtask

  task automatic wakeTest;
    RxElecIdle = 1'b0;
    tick();
    chk("wakePulse", Wake, (mCur != 2'b00) ? 1 : 0);
    tick();
    chk("wakeOneCycle", Wake, 0);
    RxElecIdle = 1'b1;
    tick();
    chk("wakeOnRise", Wake, 0);
  endtask

  task automatic strayStatus;
    PhyStatus = 1'b1;
    tick();
    PhyStatus = 1'b0;
    checkIdle("strayStatus");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    legalTab[0][1] = 1; legalTab[1][0] = 1;
    legalTab[0][2] = 1; legalTab[2][0] = 1;
    legalTab[2][3] = 1; legalTab[3][2] = 1;

    @(negedge PCLK);
    Reset_n = 1'b0;
    repeat (2) tick();
    checkResetVals("reset");
    powerUp(5);

    // Directed: P1 -> P0 -> P0s, illegal and same-state requests, wake rules.
    doReq(2'b00, 3, 0);
    setTxReq(1'b1);
    setTxReq(1'b0);
    doReq(2'b01, 2, 0);
    doReq(2'b00, 1, 0);
    doReq(2'b11, 0, 0);
    doReq(2'b00, 0, 0);
    wakeTest();
    doReq(2'b10, 2, 0);
    wakeTest();
    doReq(2'b11, 1, 0);
    wakeTest();
    doReq(2'b10, 0, 0);
    strayStatus();

    // Randomised traffic.
    for (int n = 0; n < 60; n++) begin
      int r = int'($urandom_range(0, 9));
      if (r < 6)       doReq(2'($urandom_range(0, 3)), int'($urandom_range(0, 6)), 0);
      else if (r == 6) setTxReq(1'($urandom_range(0, 1)));
      else if (r == 7) wakeTest();
      else             strayStatus();
    end

    // Walk back to P1, then abandon a P1->P2 transaction with a one-cycle reset.
    for (int n = 0; n < 3; n++) begin
      if (mCur == 2'b01)      doReq(2'b00, 1, 0);
      else if (mCur != 2'b10) doReq(2'b10, 1, 0);
    end
    chk("walkToP1", mCur, 2);
    doReq(2'b11, 0, 1);
    Reset_n = 1'b0;
    tick();
    checkResetVals("midTxnReset");
    powerUp(2);

    doTimeout(2'b11);
    Reset_n = 1'b0;
    tick();
    checkResetVals("errorReset");
    powerUp(0);
    doReq(2'b00, 1, 0);

    tick();
    tick();
    chk("pendingAtEnd", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_pm_ctrl.md
# pipe_pm_ctrl

MAC-side power-management and reset sequencer for the PIPE PHY interface. It is clocked by PCLK, sits between the link controller and the PHY's control pins, and owns the PHY's Reset, Powerdown and TxElecIdle. It runs the power-up reset handshake and serialises power-state change requests through the PhyStatus handshake. It also rejects illegal transitions, detects PHY timeouts and flags receiver wake events.

## Interface
Parameters:
- RESET_CYCLES, 16: cycles PhyReset is held low after Reset_n release (≥1).
- PHYSTATUS_TIMEOUT, 255: max cycles waiting for PhyStatus before error (≥2).

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- PmReqValid  in  1  power-state request valid.
- PmReqState  in  2  requested state: 00=P0, 01=P0s, 10=P1, 11=P2.
- PmReqReady  out  1  request accepted when PmReqValid && PmReqReady.
- TxElecIdleReq  in  1  MAC's electrical-idle request; honoured only in P0.
- PhyStatus  in  1  PHY completion pulse.
- RxElecIdle  in  1  PHY receiver electrical-idle indication.
- PhyReset  out  1  active-low reset to PHY.
- Powerdown  out  2  power state to PHY, encoding as PmReqState.
- TxElecIdle  out  1  transmitter electrical idle to PHY.
- PhyReady  out  1  PHY out of reset and sequencer operational.
- PmDone  out  1  one-cycle completion pulse.
- PmStatus  out  2  valid with PmDone: 00=ok, 01=illegal, 10=timeout.
- CurState  out  2  current committed power state.
- Wake  out  1  one-cycle pulse on receiver exiting electrical idle in a low-power state.

## Operation
- States: RST_ASSERT, RST_WAIT, IDLE, PRE_IDLE, PD_WAIT, ERROR.
- Reset values: PhyReset=0, Powerdown=10 (P1), CurState=10, TxElecIdle=1, PhyReady=0, PmReqReady=0, PmDone=0, PmStatus=00, Wake=0. FSM starts in RST_ASSERT, counters cleared.
- RST_ASSERT: PhyReset=0 for RESET_CYCLES cycles, then go to RST_WAIT.
- RST_WAIT: PhyReset=1; wait for PhyStatus=1, then go to IDLE.
- IDLE: PmReqReady=1 and PhyReady=1.
- Legal transitions: P0↔P0s, P0↔P1, P1↔P2.
- Request equal to CurState: PmDone with status 00 on the next cycle; outputs unchanged.
- Illegal request (e.g. P0s→P1, P0→P2): PmDone with status 01 on the next cycle; outputs unchanged.
- Legal request leaving P0: go to PRE_IDLE, which forces TxElecIdle=1 for one cycle. Then go to PD_WAIT with Powerdown = the new state.
- Legal request not leaving P0: go directly to PD_WAIT with Powerdown = the new state.
- PD_WAIT: PmReqReady=0. On PhyStatus=1: CurState updates, PmDone with status 00, return to IDLE.
- TxElecIdle: 1 whenever CurState≠P0 or FSM≠IDLE. In IDLE with CurState=P0 it equals TxElecIdleReq, registered with one-cycle latency.
- Timeout: a counter runs in RST_WAIT and PD_WAIT. When it reaches PHYSTATUS_TIMEOUT with no PhyStatus, go to ERROR.
  - Timeout from PD_WAIT also issues PmDone with status 10.
  - In ERROR: PhyReady=0, PmReqReady=0, TxElecIdle=1, Powerdown holds. The only exit is reset.
- PhyStatus and timeout in the same cycle: PhyStatus wins.
- PhyStatus in RST_ASSERT, IDLE, PRE_IDLE or ERROR: ignored.
- Wake: RxElecIdle is registered. A 1→0 edge seen in IDLE with CurState≠P0 pulses Wake for one cycle. No automatic state change follows.
- Reset_n low mid-transaction: at the next edge all outputs take their reset values, and the transaction is abandoned without PmDone.

## Timing
- All outputs are registered.
- Reset release: let cycle 0 be the first edge with Reset_n=1.
  - PhyReset=0 through cycle RESET_CYCLES−1; PhyReset=1 from cycle RESET_CYCLES.
  - PhyStatus sampled high at cycle K → PhyReady=1 and PmReqReady=1 at K+1.
- Request leaving P0, accepted at cycle N:
  - N+1: TxElecIdle=1, PmReqReady=0.
  - N+2: Powerdown changes.
  - PhyStatus sampled at M: CurState updates, PmDone and PmReqReady=1 at M+1.
- Request to P0 or between low-power states, accepted at N: Powerdown changes at N+1; completion as above.
- Same-state or illegal request accepted at N: PmDone at N+1, PmReqReady stays 1.
- Timeout counter starts at 0 on PD_WAIT/RST_WAIT entry. ERROR is entered on the edge after the counter reaches PHYSTATUS_TIMEOUT−1 with no PhyStatus.
- Back-to-back: a new request may be accepted in the same cycle that PmDone pulses.

## Test plan
- Power-up: release Reset_n, PhyStatus pulse 5 cycles after PhyReset rises → PhyReset low exactly 16 cycles; PhyReady=1 one cycle after PhyStatus; Powerdown=10, CurState=10.
- P1→P0→P0s: request 00, PhyStatus after 3 cycles → PmDone/00, CurState=00, TxElecIdle follows TxElecIdleReq. Then request 01 → TxElecIdle=1 one cycle before Powerdown=01.
- Illegal P0→P2 request → PmDone/01 on the next cycle; Powerdown, CurState and TxElecIdle unchanged.
- Timeout: request P1→P2 with PhyStatus never asserted → PmDone/10 after 255 cycles; ERROR holds PmReqReady=0 and PhyReady=0 until Reset_n.
- Wake: CurState=10 in IDLE, RxElecIdle 1→0 → single Wake pulse; no Wake when CurState=00.
- Reset mid-PD_WAIT: Reset_n low for one cycle → all outputs at reset values next edge, no PmDone, full power-up sequence restarts.
